// File: rtl/block_nest_checker.sv
// Purpose : streaming begin/end nesting checker over an ASCII byte stream; case-insensitive, whole-word keywords.
// Latency : outputs are combinational from registers and reflect a byte from the clock edge that accepts it.
// Backpr. : none; a byte is consumed on every rising edge with in_valid=1. Bytes are ignored once error is set.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   qualifies the byte on 'in'
//   in         ASCII byte
//   result     1 = stream so far is balanced and error-free (an unfinished keyword counts as if the stream ended)
//   depth      committed nesting depth (keywords terminated by a delimiter)
//   error      sticky underflow/overflow flag
//   max_depth  high-water mark of depth (only when BNC_MAXDEPTH_EN is defined)
//
// Parameters: DEPTH_W (counter width), DELIM_MODE (0: space only, 1: any non-letter is a delimiter)
// Optional feature macro: BNC_MAXDEPTH_EN
module block_nest_checker #(
    parameter int DEPTH_W    = 8,
    parameter int DELIM_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
`ifdef BNC_MAXDEPTH_EN
    output logic [DEPTH_W-1:0] max_depth,
`endif
    output logic               error
);

    typedef enum logic [3:0] {
        S_DLM, S_B1, S_B2, S_B3, S_B4, S_B5, S_E1, S_E2, S_E3, S_OTH
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               error_q, error_d;
`ifdef BNC_MAXDEPTH_EN
    logic [DEPTH_W-1:0] max_q, max_d;
`endif

    logic       is_upper;
    logic       is_lower;
    logic       is_letter;
    logic       is_delim;
    logic [7:0] ch;

    assign is_upper  = (in >= 8'h41) && (in <= 8'h5A);
    assign is_lower  = (in >= 8'h61) && (in <= 8'h7A);
    assign is_letter = is_upper || is_lower;
    // Only letters are folded; a folded non-letter never equals a keyword
    // letter, so in space-only mode punctuation naturally drops to S_OTH.
    assign ch        = is_upper ? (in | 8'h20) : in;
    assign is_delim  = (DELIM_MODE == 1) ? !is_letter : (in == 8'h20);

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        error_d = error_q;
`ifdef BNC_MAXDEPTH_EN
        max_d   = max_q;
`endif
        if (in_valid && !error_q) begin
            if (is_delim) begin
                state_d = S_DLM;
                if (state_q == S_B5) begin
                    if (depth_q == DEPTH_MAX) begin
                        error_d = 1'b1;
                    end else begin
                        depth_d = depth_q + DEPTH_ONE;
`ifdef BNC_MAXDEPTH_EN
                        if ((depth_q + DEPTH_ONE) > max_q) max_d = depth_q + DEPTH_ONE;
`endif
                    end
                end else if (state_q == S_E3) begin
                    if (depth_q == '0) error_d = 1'b1;
                    else               depth_d = depth_q - DEPTH_ONE;
                end
            end else begin
                state_d = S_OTH;
                case (state_q)
                    S_DLM: begin
                        if (ch == 8'h62)      state_d = S_B1; // b
                        else if (ch == 8'h65) state_d = S_E1; // e
                    end
                    S_B1: if (ch == 8'h65) state_d = S_B2;    // e
                    S_B2: if (ch == 8'h67) state_d = S_B3;    // g
                    S_B3: if (ch == 8'h69) state_d = S_B4;    // i
                    S_B4: if (ch == 8'h6E) state_d = S_B5;    // n
                    S_E1: if (ch == 8'h6E) state_d = S_E2;    // n
                    S_E2: if (ch == 8'h64) state_d = S_E3;    // d
                    default: state_d = S_OTH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_DLM;
            depth_q <= '0;
            error_q <= 1'b0;
`ifdef BNC_MAXDEPTH_EN
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            error_q <= error_d;
`ifdef BNC_MAXDEPTH_EN
            max_q   <= max_d;
`endif
        end
    end

    // A pending keyword is judged as if a delimiter followed it now.
    assign result = !error_q &&
                    (((depth_q == '0) && (state_q != S_B5) && (state_q != S_E3)) ||
                     ((depth_q == DEPTH_ONE) && (state_q == S_E3)));
    assign depth  = depth_q;
    assign error  = error_q;
`ifdef BNC_MAXDEPTH_EN
    assign max_depth = max_q;
`endif

endmodule

// File: tb/tb_block_nest_checker.sv
// Purpose : self-checking bench driving one byte stream into three configurations of block_nest_checker.
// Latency : expected values queued when a byte is driven, compared #1 after the accepting edge.
// Backpr. : n/a
module tb_block_nest_checker;

    typedef struct packed {
        logic       r;
        logic [7:0] d;
        logic       e;
        logic [7:0] m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_dat = 8'h00;

    logic       r_o [3];
    logic [7:0] d_o [3];
    logic       e_o [3];
    logic [7:0] m_o [3];

    logic [7:0] dep_a, dep_b;
    logic [1:0] dep_c;
`ifdef BNC_MAXDEPTH_EN
    logic [7:0] mx_a, mx_b;
    logic [1:0] mx_c;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // model state per instance
    int         mdep [3];
    int         mmax [3];
    bit         merr [3];
    logic [7:0] wbuf [3][8];
    int         wlen [3];
    int         mode_c [3] = '{0, 1, 0};
    int         maxv   [3] = '{255, 255, 3};

    always #5 clk = ~clk;

    block_nest_checker #(.DEPTH_W(8), .DELIM_MODE(0)) u_d8 (
        .clk(clk), .reset(rst_n), .in_valid(in_vld), .in(in_dat),
        .result(r_o[0]), .depth(dep_a),
`ifdef BNC_MAXDEPTH_EN
        .max_depth(mx_a),
`endif
        .error(e_o[0]));

    block_nest_checker #(.DEPTH_W(8), .DELIM_MODE(1)) u_m1 (
        .clk(clk), .reset(rst_n), .in_valid(in_vld), .in(in_dat),
        .result(r_o[1]), .depth(dep_b),
`ifdef BNC_MAXDEPTH_EN
        .max_depth(mx_b),
`endif
        .error(e_o[1]));

    block_nest_checker #(.DEPTH_W(2), .DELIM_MODE(0)) u_w2 (
        .clk(clk), .reset(rst_n), .in_valid(in_vld), .in(in_dat),
        .result(r_o[2]), .depth(dep_c),
`ifdef BNC_MAXDEPTH_EN
        .max_depth(mx_c),
`endif
        .error(e_o[2]));

    assign d_o[0] = dep_a;
    assign d_o[1] = dep_b;
    assign d_o[2] = {6'b0, dep_c};
`ifdef BNC_MAXDEPTH_EN
    assign m_o[0] = mx_a;
    assign m_o[1] = mx_b;
    assign m_o[2] = {6'b0, mx_c};
`else
    assign m_o[0] = 8'h00;
    assign m_o[1] = 8'h00;
    assign m_o[2] = 8'h00;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit word_is(input int i, input logic [39:0] pat, input int n);
        if (wlen[i] != n) return 1'b0;
        for (int k = 0; k < n; k++)
            if (wbuf[i][k] != pat[8*(n-1-k) +: 8]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            mdep[i] = 0; mmax[i] = 0; merr[i] = 1'b0; wlen[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [7:0] b);
        bit letter, delim;
        logic [7:0] lc;
        for (int i = 0; i < 3; i++) begin
            if (merr[i]) continue;
            letter = (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
            lc     = (b >= "A" && b <= "Z") ? b + 8'd32 : b;
            delim  = (mode_c[i] == 1) ? !letter : (b == " ");
            if (delim) begin
                if (word_is(i, "begin", 5)) begin
                    if (mdep[i] == maxv[i]) merr[i] = 1'b1;
                    else begin
                        mdep[i]++;
                        if (mdep[i] > mmax[i]) mmax[i] = mdep[i];
                    end
                end else if (word_is(i, "end", 3)) begin
                    if (mdep[i] == 0) merr[i] = 1'b1;
                    else mdep[i]--;
                end
                wlen[i] = 0;
            end else begin
                if (wlen[i] < 8) wbuf[i][wlen[i]] = lc;
                wlen[i]++;
            end
        end
    endfunction

    task automatic push_exp();
        exp_t e;
        bit pb, pe;
        for (int i = 0; i < 3; i++) begin
            pb = word_is(i, "begin", 5);
            pe = word_is(i, "end", 3);
            e.r = !merr[i] && ((mdep[i] == 0 && !pb && !pe) || (mdep[i] == 1 && pe));
            e.d = 8'(mdep[i]);
            e.e = merr[i];
            e.m = 8'(mmax[i]);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_res_u%0d", tag, i), 32'(r_o[i]), 32'(e.r));
            chk($sformatf("%s_dep_u%0d", tag, i), 32'(d_o[i]), 32'(e.d));
            chk($sformatf("%s_err_u%0d", tag, i), 32'(e_o[i]), 32'(e.e));
`ifdef BNC_MAXDEPTH_EN
            chk($sformatf("%s_max_u%0d", tag, i), 32'(m_o[i]), 32'(e.m));
`endif
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        model_clear();
        push_exp();
        #1;
        check_all({tag, "_rst"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic v);
        @(negedge clk);
        in_dat = b;
        in_vld = v;
        if (v) model_step(b);
        push_exp();
        @(posedge clk);
        #1;
        check_all(tag);
        in_vld = 1'b0;
    endtask

    task automatic send_str(input string tag, input string s, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            send(tag, s[i], 1'b1);
            if (gap) send({tag, "_gap"}, 8'h65, 1'b0);
        end
    endtask

    initial begin
        model_clear();
        do_reset("t0");

        send_str("t1", "Begin eND ", 1'b0);
        chk("t1_final_res", 32'(r_o[0]), 32'd1);
        do_reset("t1");

        send_str("t2", "begin", 1'b0);
        chk("t2_pending_res", 32'(r_o[0]), 32'd0);
        send_str("t2", " ", 1'b0);
        chk("t2_depth", 32'(d_o[0]), 32'd1);
        do_reset("t2");

        send_str("t3", "end begin end ", 1'b0);
        chk("t3_err", 32'(e_o[0]), 32'd1);
        do_reset("t3");
        chk("t3_res_after_reset", 32'(r_o[0]), 32'd1);

        send_str("t4", "beginx endd begi ", 1'b0);
        do_reset("t4");

        send_str("t5", "begin;begin(end)end.", 1'b0);
        chk("t5_m1_res", 32'(r_o[1]), 32'd1);
        chk("t5_m0_res", 32'(r_o[0]), 32'd1);
        // reset mid-word: next byte follows a delimiter
        send_str("t5b", "be", 1'b0);
        do_reset("t5b");
        send_str("t5c", "gin end ", 1'b0);
        do_reset("t5c");

        send_str("t6", "begin begin begin begin ", 1'b1);
        chk("t6_w2_err", 32'(e_o[2]), 32'd1);
        chk("t6_w2_dep", 32'(d_o[2]), 32'd3);
        send_str("t6_frozen", "end ", 1'b0);
        do_reset("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
